// File: rtl/count_seq_pkg.sv
// Shared types for the count sequencer: FSM state encoding and default counter width.
// The state values are visible on the debug LEDs, so their encoding is fixed.
package count_seq_pkg;

  localparam int DEFAULT_CNT_W = 4;
  localparam int STATE_W       = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  function automatic logic is_busy(input state_t st);
    return (st == ST_LOAD) || (st == ST_RUN) || (st == ST_PAUSE);
  endfunction

endpackage

// File: rtl/count_seq_edge.sv
// Registered rising-edge detector: pulse is high while in is high and was low last cycle.
module edge_rise (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic pulse
);

  logic prev;

  // prev clears on reset so a level held through reset yields one edge afterwards
  always_ff @(posedge clk) begin
    if (reset) begin
      prev <= 1'b0;
    end else begin
      prev <= in;
    end
  end

  assign pulse = in & ~prev;

endmodule

// File: rtl/count_sequencer.sv
// Control FSM pacing an external down-counter with a prescaler tick and start/pause edges.
// Optional: define COUNT_SEQ_AUTORELOAD_EN to reload the last start value after each DONE.
module count_sequencer
  import count_seq_pkg::*;
#(
  parameter int TICK_DIV = 25_000_000,
  parameter int CNT_W    = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pause,
  input  logic [CNT_W-1:0] start_value,
  input  logic [CNT_W-1:0] count,
  output logic             cnt_load,
  output logic [CNT_W-1:0] cnt_load_val,
  output logic             cnt_en,
  output logic             busy,
  output logic             done,
  output logic [2:0]       state
);

  localparam int             PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0]  TICK_LAST = PW'(TICK_DIV - 1);

  state_t           cur_state;
  state_t           nxt_state;
  logic [PW-1:0]    presc;
  logic [PW-1:0]    presc_nxt;
  logic [CNT_W-1:0] val_nxt;
  logic             load_nxt;
  logic             en_nxt;
  logic             done_nxt;
  logic             start_rise;
  logic             pause_rise;
  logic             tick;

  edge_rise u_start_edge (
    .clk   (clk),
    .reset (reset),
    .in    (start),
    .pulse (start_rise)
  );

  edge_rise u_pause_edge (
    .clk   (clk),
    .reset (reset),
    .in    (pause),
    .pulse (pause_rise)
  );

  assign tick = (presc == TICK_LAST);

  // Next-state logic; start outranks pause, and a pause edge in RUN suppresses that cycle's tick
  always_comb begin
    nxt_state = cur_state;
    presc_nxt = presc;
    val_nxt   = cnt_load_val;
    en_nxt    = 1'b0;
    done_nxt  = 1'b0;

    case (cur_state)
      ST_IDLE: begin
        if (start_rise) begin
          val_nxt   = start_value;
          nxt_state = ST_LOAD;
        end
      end

      ST_LOAD: begin
        presc_nxt = '0;
        nxt_state = ST_RUN;
      end

      ST_RUN: begin
        if (start_rise) begin
          val_nxt   = start_value;
          nxt_state = ST_LOAD;
        end else if (pause_rise) begin
          nxt_state = ST_PAUSE;
        end else if (tick) begin
          presc_nxt = '0;
          if (count == '0) begin
            done_nxt  = 1'b1;
            nxt_state = ST_DONE;
          end else begin
            en_nxt = 1'b1;
          end
        end else begin
          presc_nxt = presc + 1'b1;
        end
      end

      ST_PAUSE: begin
        if (start_rise) begin
          val_nxt   = start_value;
          nxt_state = ST_LOAD;
        end else if (pause_rise) begin
          nxt_state = ST_RUN;
        end
      end

      ST_DONE: begin
        if (start_rise) begin
          val_nxt   = start_value;
          nxt_state = ST_LOAD;
        end else begin
`ifdef COUNT_SEQ_AUTORELOAD_EN
          nxt_state = ST_LOAD;
`else
          nxt_state = ST_DONE;
`endif
        end
      end

      default: begin
        nxt_state = ST_IDLE;
      end
    endcase

    load_nxt = (nxt_state == ST_LOAD);
  end

  // Strobes are registered alongside the state so each lasts exactly one cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state    <= ST_IDLE;
      presc        <= '0;
      cnt_load_val <= '0;
      cnt_load     <= 1'b0;
      cnt_en       <= 1'b0;
      done         <= 1'b0;
    end else begin
      cur_state    <= nxt_state;
      presc        <= presc_nxt;
      cnt_load_val <= val_nxt;
      cnt_load     <= load_nxt;
      cnt_en       <= en_nxt;
      done         <= done_nxt;
    end
  end

  assign busy  = is_busy(cur_state);
  assign state = cur_state;

endmodule

// File: tb/tb_count_sequencer.sv
// Randomized and directed bench for count_sequencer with a behavioural down-counter.
// The reference model tracks elapsed RUN cycles and derives ticks and terminal count arithmetically.
module tb_count_sequencer;

  localparam int TD = 4;

  logic       clk;
  logic       reset;
  logic       start;
  logic       pause;
  logic [3:0] start_value;
  logic [3:0] count;
  logic       cnt_load;
  logic [3:0] cnt_load_val;
  logic       cnt_en;
  logic       busy;
  logic       done;
  logic [2:0] state;

  int testCount = 0;
  int failCount = 0;

  // model state: mode uses the published encoding 0..4
  int mMode    = 0;
  int mElapsed = 0;
  int mVal     = 0;
  int mCount   = 0;
  bit mPrevS   = 0;
  bit mPrevP   = 0;
  bit eLoad    = 0;
  bit eEn      = 0;
  bit eDone    = 0;

  count_sequencer #(.TICK_DIV(TD), .CNT_W(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .pause        (pause),
    .start_value  (start_value),
    .count        (count),
    .cnt_load     (cnt_load),
    .cnt_load_val (cnt_load_val),
    .cnt_en       (cnt_en),
    .busy         (busy),
    .done         (done),
    .state        (state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // behavioural down-counter sharing the sequencer's reset
  always @(posedge clk) begin
    if (reset) count <= 4'd0;
    else if (cnt_load) count <= cnt_load_val;
    else if (cnt_en) count <= count - 4'd1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  // Advance the model across one rising edge given the inputs applied for that cycle
  task automatic modelStep(input bit s, input bit p, input bit r, input int sv);
    bit sr;
    bit pr;
    if (r) begin
      mMode = 0; mElapsed = 0; mVal = 0; mCount = 0;
      mPrevS = 0; mPrevP = 0; eLoad = 0; eEn = 0; eDone = 0;
      return;
    end
    if (eLoad) mCount = mVal;
    else if (eEn) mCount = (mCount + 15) % 16;
    sr = s && !mPrevS;
    pr = p && !mPrevP;
    mPrevS = s;
    mPrevP = p;
    eEn = 0;
    eDone = 0;
    if (mMode == 1) begin
      mMode = 2;
      mElapsed = 0;
    end else if (sr) begin
      mVal = sv;
      mMode = 1;
    end else if (mMode == 2 && pr) begin
      mMode = 3;
    end else if (mMode == 3 && pr) begin
      mMode = 2;
    end else if (mMode == 2) begin
      mElapsed++;
      if (mElapsed % TD == 0) begin
        if (mElapsed / TD == mVal + 1) begin
          eDone = 1;
          mMode = 4;
        end else begin
          eEn = 1;
        end
      end
    end
    eLoad = (mMode == 1);
  endtask

  task automatic checkAll();
    checkOutput("state", 32'(state), 32'(mMode));
    checkOutput("busy", 32'(busy), 32'(mMode >= 1 && mMode <= 3));
    checkOutput("cnt_load", 32'(cnt_load), 32'(eLoad));
    checkOutput("cnt_load_val", 32'(cnt_load_val), 32'(mVal));
    checkOutput("cnt_en", 32'(cnt_en), 32'(eEn));
    checkOutput("done", 32'(done), 32'(eDone));
    checkOutput("count", 32'(count), 32'(mCount));
  endtask

  // Drive one cycle of inputs just after a falling edge, then check after the next rising edge
  task automatic applyStimulus(input bit s, input bit p, input bit r, input logic [3:0] sv);
    start = s;
    pause = p;
    reset = r;
    start_value = sv;
    modelStep(s, p, r, int'(sv));
    @(negedge clk);
    checkAll();
  endtask

  task automatic holdFor(input int n, input bit s, input bit p, input logic [3:0] sv);
    for (int i = 0; i < n; i++) applyStimulus(s, p, 1'b0, sv);
  endtask

  initial begin
    bit rs;
    bit rp;
    start = 0;
    pause = 0;
    reset = 1;
    start_value = 0;

    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, 1'b1, 4'd0);

    // basic countdown from 3
    holdFor(1, 1'b0, 1'b0, 4'd3);
    holdFor(24, 1'b1, 1'b0, 4'd3);
    holdFor(2, 1'b0, 1'b0, 4'd7);

    // pause after first strobe, hold paused, resume mid-prescale
    holdFor(8, 1'b1, 1'b0, 4'd5);
    holdFor(21, 1'b1, 1'b1, 4'd5);
    holdFor(2, 1'b1, 1'b0, 4'd5);
    holdFor(10, 1'b1, 1'b1, 4'd5);

    // restart mid-run with 9
    holdFor(1, 1'b0, 1'b0, 4'd9);
    holdFor(5, 1'b1, 1'b0, 4'd9);
    holdFor(45, 1'b1, 1'b0, 4'd2);

    // zero load
    holdFor(1, 1'b0, 1'b0, 4'd0);
    holdFor(10, 1'b1, 1'b0, 4'd0);

    // simultaneous start and pause edges, then reset mid-run
    holdFor(1, 1'b0, 1'b0, 4'd6);
    holdFor(9, 1'b1, 1'b1, 4'd6);
    applyStimulus(1'b1, 1'b1, 1'b1, 4'd6);
    holdFor(6, 1'b1, 1'b1, 4'd6);

    // randomized traffic
    rs = 0;
    rp = 0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 19) == 0) rs = !rs;
      if ($urandom_range(0, 24) == 0) rp = !rp;
      applyStimulus(rs, rp, ($urandom_range(0, 299) == 0), 4'($urandom_range(0, 15)));
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
